// File: rtl/dig_alarm_clock_pkg.sv
// Shared types and helpers for the alarm clock core.
// The optional snooze feature is enabled by defining DIG_CLOCK_SNOOZE_EN.
package dig_alarm_clock_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HR   = 3'd1,
      SET_MIN  = 3'd2,
      SET_AHR  = 3'd3,
      SET_AMIN = 3'd4
   } mode_t;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   // Binary 0..63 to two BCD digits {tens, ones}.
   function automatic logic [7:0] bin2bcd(input logic [5:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 6'd10);
      ones = 4'(v - 6'(tens) * 6'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/dig_alarm_clock_if.sv
// Button/display bundle between the pulsed buttons, the clock core and the display driver.
// The snoozing output exists only when DIG_CLOCK_SNOOZE_EN is defined.
interface dig_alarm_clock_if;
   import dig_alarm_clock_pkg::*;

   logic       btn_mode;
   logic       btn_inc;
   logic       mode24;
   logic [3:0] h1, h0, m1, m0, s1, s0;
   logic       pm;
   logic       armed;
   logic       ring;
   logic       blink;
   mode_t      mode;
`ifdef DIG_CLOCK_SNOOZE_EN
   logic       snoozing;
`endif

   modport master (
      output btn_mode, btn_inc, mode24,
`ifdef DIG_CLOCK_SNOOZE_EN
      input  snoozing,
`endif
      input  h1, h0, m1, m0, s1, s0, pm, armed, ring, blink, mode
   );

   modport slave (
      input  btn_mode, btn_inc, mode24,
`ifdef DIG_CLOCK_SNOOZE_EN
      output snoozing,
`endif
      output h1, h0, m1, m0, s1, s0, pm, armed, ring, blink, mode
   );

endinterface

// File: rtl/dig_alarm_clock_mod_counter.sv
// Wrapping modulo counter 0..MAX with synchronous clear and a carry-out
// pulse on the increment that wraps back to zero.
module mod_counter #(
   parameter int MAX     = 59,
   parameter int W       = 6,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] q_o,
   output logic         co_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over increment, wrap at MAX.
   always_comb begin
      cnt_d = cnt_q;
      co_o  = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         if (cnt_q == W'(MAX)) begin
            cnt_d = '0;
            co_o  = 1'b1;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= W'(RST_VAL);
      else        cnt_q <= cnt_d;
   end

   assign q_o = cnt_q;

endmodule

// File: rtl/dig_alarm_clock.sv
// Time-of-day core: self-timed seconds, set-mode FSM, 12/24 h display and one alarm.
// Defining DIG_CLOCK_SNOOZE_EN turns a dismiss into a snooze and adds bus.snoozing.
//
// state    | meaning
// RUN      | time runs, btn_inc toggles armed
// SET_HR   | time frozen, btn_inc advances hour
// SET_MIN  | time frozen, btn_inc advances minute (no hour carry)
// SET_AHR  | time runs, btn_inc advances alarm hour
// SET_AMIN | time runs, btn_inc advances alarm minute
module dig_alarm_clock
   import dig_alarm_clock_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_MIN  = 9,
   parameter int ALM_RST_HR  = 6,
   parameter int ALM_RST_MIN = 0
) (
   input logic               clk,
   input logic               rst_n,
   dig_alarm_clock_if.slave  bus
);

   localparam int             PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PS_TC   = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0]  PS_HALF = PW'(CLK_HZ / 2);
   localparam logic [7:0]     RING_TC = 8'(RING_SECS);

   if (CLK_HZ < 2 || RING_SECS < 1 || RING_SECS > 255 || SNOOZE_MIN < 1 ||
       ALM_RST_HR > HR_MAX || ALM_RST_MIN > MIN_MAX) begin : g_param_chk
      $error("dig_alarm_clock: parameter out of range");
   end

   mode_t         mode_q, mode_d;
   logic [PW-1:0] ps_q, ps_d;
   logic          armed_q, armed_d;
   logic          ring_q, ring_d;
   logic [7:0]    ring_cnt_q, ring_cnt_d;
   logic          tick_q;
   logic          sec_tick, enter_set, time_run, inc_ev, edit_ev, alarm_hit;
   logic [5:0]    sec, min, alm_min;
   logic [4:0]    hr, alm_hr;
   logic          sec_co, min_co, hr_co, ahr_co, amin_co;
   logic          co_unused;
   logic [4:0]    disp_hr, hr_shown;
   logic [5:0]    disp_min, disp_sec;
   logic [7:0]    hr_bcd, min_bcd, sec_bcd;

`ifdef DIG_CLOCK_SNOOZE_EN
   localparam int SNZ_SECS = SNOOZE_MIN * 60;
   localparam int SNZ_W    = $clog2(SNZ_SECS + 1);
   logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
   logic             snoozing_q, snoozing_d;
`endif

   assign sec_tick  = (ps_q == PS_TC);
   assign enter_set = bus.btn_mode && (mode_q == RUN);
   assign time_run  = (mode_q != SET_HR) && (mode_q != SET_MIN);
   assign inc_ev    = bus.btn_inc && !bus.btn_mode;
   assign edit_ev   = inc_ev && !ring_q;
   // Only a real second tick can match the alarm, never an edit.
   assign alarm_hit = armed_q && tick_q && (hr == alm_hr) && (min == alm_min) && (sec == '0);
   assign ps_d      = (enter_set || sec_tick) ? '0 : ps_q + PW'(1);
   assign co_unused = hr_co | ahr_co | amin_co;

   mod_counter #(.MAX(SEC_MAX), .W(6), .RST_VAL(0)) u_sec (
      .clk(clk), .rst_n(rst_n), .clr_i(enter_set), .inc_i(sec_tick && time_run),
      .q_o(sec), .co_o(sec_co));

   mod_counter #(.MAX(MIN_MAX), .W(6), .RST_VAL(0)) u_min (
      .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
      .inc_i(sec_co || (edit_ev && mode_q == SET_MIN)),
      .q_o(min), .co_o(min_co));

   mod_counter #(.MAX(HR_MAX), .W(5), .RST_VAL(0)) u_hr (
      .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
      .inc_i((min_co && time_run) || (edit_ev && mode_q == SET_HR)),
      .q_o(hr), .co_o(hr_co));

   mod_counter #(.MAX(HR_MAX), .W(5), .RST_VAL(ALM_RST_HR)) u_alm_hr (
      .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(edit_ev && mode_q == SET_AHR),
      .q_o(alm_hr), .co_o(ahr_co));

   mod_counter #(.MAX(MIN_MAX), .W(6), .RST_VAL(ALM_RST_MIN)) u_alm_min (
      .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(edit_ev && mode_q == SET_AMIN),
      .q_o(alm_min), .co_o(amin_co));

   // Mode sequencing: one step per btn_mode pulse.
   always_comb begin
      mode_d = mode_q;
      if (bus.btn_mode) begin
         case (mode_q)
            RUN:      mode_d = SET_HR;
            SET_HR:   mode_d = SET_MIN;
            SET_MIN:  mode_d = SET_AHR;
            SET_AHR:  mode_d = SET_AMIN;
            default:  mode_d = RUN;
         endcase
      end
   end

   // Arm, ring, self-clear and dismiss/snooze; trigger beats dismiss, disarm beats all.
   always_comb begin
      armed_d    = armed_q;
      ring_d     = ring_q;
      ring_cnt_d = ring_cnt_q;
`ifdef DIG_CLOCK_SNOOZE_EN
      snz_cnt_d  = snz_cnt_q;
      snoozing_d = snoozing_q;
`endif
      if (ring_q && sec_tick) begin
         if (ring_cnt_q == 8'd1) ring_d = 1'b0;
         else                    ring_cnt_d = ring_cnt_q - 8'd1;
      end
`ifdef DIG_CLOCK_SNOOZE_EN
      if (snoozing_q && sec_tick) begin
         if (snz_cnt_q == SNZ_W'(1)) begin
            snoozing_d = 1'b0;
            ring_d     = 1'b1;
            ring_cnt_d = RING_TC;
         end else begin
            snz_cnt_d = snz_cnt_q - SNZ_W'(1);
         end
      end
`endif
      if (inc_ev && ring_q) begin
         ring_d = 1'b0;
`ifdef DIG_CLOCK_SNOOZE_EN
         snoozing_d = 1'b1;
         snz_cnt_d  = SNZ_W'(SNZ_SECS);
`endif
      end else if (inc_ev && mode_q == RUN) begin
         armed_d = !armed_q;
      end
      if (alarm_hit) begin
         ring_d     = 1'b1;
         ring_cnt_d = RING_TC;
`ifdef DIG_CLOCK_SNOOZE_EN
         snoozing_d = 1'b0;
`endif
      end
      if (!armed_d) begin
         ring_d = 1'b0;
`ifdef DIG_CLOCK_SNOOZE_EN
         snoozing_d = 1'b0;
`endif
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= RUN;
         ps_q       <= '0;
         armed_q    <= 1'b0;
         ring_q     <= 1'b0;
         ring_cnt_q <= '0;
         tick_q     <= 1'b0;
`ifdef DIG_CLOCK_SNOOZE_EN
         snz_cnt_q  <= '0;
         snoozing_q <= 1'b0;
`endif
      end else begin
         mode_q     <= mode_d;
         ps_q       <= ps_d;
         armed_q    <= armed_d;
         ring_q     <= ring_d;
         ring_cnt_q <= ring_cnt_d;
         tick_q     <= sec_tick && time_run && !enter_set;
`ifdef DIG_CLOCK_SNOOZE_EN
         snz_cnt_q  <= snz_cnt_d;
         snoozing_q <= snoozing_d;
`endif
      end
   end

   // Display source (time or alarm) and 12 h mapping.
   always_comb begin
      disp_hr  = hr;
      disp_min = min;
      disp_sec = sec;
      if (mode_q == SET_AHR || mode_q == SET_AMIN) begin
         disp_hr  = alm_hr;
         disp_min = alm_min;
         disp_sec = '0;
      end
      hr_shown = disp_hr;
      if (!bus.mode24) begin
         if (disp_hr == 5'd0)       hr_shown = 5'd12;
         else if (disp_hr > 5'd12)  hr_shown = disp_hr - 5'd12;
      end
   end

   assign hr_bcd  = bin2bcd({1'b0, hr_shown});
   assign min_bcd = bin2bcd(disp_min);
   assign sec_bcd = bin2bcd(disp_sec);

   assign bus.h1    = hr_bcd[7:4];
   assign bus.h0    = hr_bcd[3:0];
   assign bus.m1    = min_bcd[7:4];
   assign bus.m0    = min_bcd[3:0];
   assign bus.s1    = sec_bcd[7:4];
   assign bus.s0    = sec_bcd[3:0];
   assign bus.pm    = (disp_hr >= 5'd12);
   assign bus.armed = armed_q;
   assign bus.ring  = ring_q;
   assign bus.blink = (mode_q != RUN) && (ps_q < PS_HALF);
   assign bus.mode  = mode_q;
`ifdef DIG_CLOCK_SNOOZE_EN
   assign bus.snoozing = snoozing_q;
`endif

endmodule
